// File: rtl/water_pkg.sv
// Shared types and constants for the irrigation sequencer.
package water_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WATER,
    ST_COOLDOWN,
    ST_FAULT
  } state_e;

  localparam logic [1:0] WL_EMPTY = 2'b00;
  localparam logic [1:0] WL_LOW   = 2'b01;
  localparam logic [1:0] WL_MID   = 2'b10;
  localparam logic [1:0] WL_FULL  = 2'b11;

  localparam logic [7:0] DEFAULT_DRY_THRESH = 8'd64;

endpackage

// File: rtl/water_scheduler_if.sv
// Sensor inputs and actuator outputs of the irrigation sequencer.
interface water_scheduler_if #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned ZW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
);
  logic [8*N_ZONES-1:0] Moisture_sensor;
  logic [1:0]           Water_sensor;
  logic                 Pump;
  logic [N_ZONES-1:0]   Sprinkler;
  logic [ZW-1:0]        Active_zone;
  logic                 Busy;
  logic                 Fault;

  modport master (
    output Moisture_sensor, Water_sensor,
    input  Pump, Sprinkler, Active_zone, Busy, Fault
  );

  modport slave (
    input  Moisture_sensor, Water_sensor,
    output Pump, Sprinkler, Active_zone, Busy, Fault
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above the last grant, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/water_scheduler.sv
// Irrigation sequencer: hysteretic tank refill and round-robin zone watering,
// pump and sprinklers mutually exclusive, sticky refill-timeout fault.
module water_scheduler
  import water_pkg::*;
#(
  parameter int unsigned N_ZONES         = 4,
  parameter logic [7:0]  DRY_THRESH      = DEFAULT_DRY_THRESH,
  parameter int unsigned RUN_CYCLES      = 16,
  parameter int unsigned COOLDOWN_CYCLES = 8,
  parameter int unsigned REFILL_TIMEOUT  = 64
) (
  input  logic              CLK,
  input  logic              Reset,
  water_scheduler_if.slave  io
);

  localparam int unsigned ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int unsigned RW = $clog2(RUN_CYCLES) + 1;
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES) + 1;
  localparam int unsigned FW = $clog2(REFILL_TIMEOUT) + 1;

  localparam logic [RW-1:0] RUN_LOAD    = RW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD   = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [FW-1:0] REFILL_LAST = FW'(REFILL_TIMEOUT - 1);
  localparam logic [ZW-1:0] LAST_INIT   = ZW'(N_ZONES - 1);

  state_e              state_q, state_d;
  logic [RW-1:0]       run_q, run_d;
  logic [CW-1:0]       cool_q, cool_d;
  logic [FW-1:0]       refill_q, refill_d;
  logic [ZW-1:0]       last_q, last_d;
  logic [ZW-1:0]       zone_q, zone_d;
  logic                pump_q, pump_d;
  logic [N_ZONES-1:0]  spr_q, spr_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic [N_ZONES-1:0]  req;
  logic [N_ZONES-1:0]  arb_grant;
  logic [ZW-1:0]       arb_idx;
  logic                empty;

  always_comb begin
    req = '0;
    for (int unsigned z = 0; z < N_ZONES; z++) begin
      req[z] = io.Moisture_sensor[8*z +: 8] < DRY_THRESH;
    end
  end

  rr_arbiter #(
    .N (N_ZONES),
    .W (ZW)
  ) u_arb (
    .req       (req),
    .last      (last_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign empty = (io.Water_sensor == WL_EMPTY);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    cool_d   = cool_q;
    refill_d = refill_q;
    last_d   = last_q;
    zone_d   = zone_q;

    unique case (state_q)
      ST_IDLE: begin
        if (empty) begin
          state_d  = ST_REFILL;
          refill_d = '0;
        end else if (|arb_grant) begin
          state_d = ST_WATER;
          run_d   = RUN_LOAD;
          last_d  = arb_idx;
          zone_d  = arb_idx;
        end
      end
      ST_REFILL: begin
        if (io.Water_sensor == WL_FULL) begin
          state_d = ST_COOLDOWN;
          cool_d  = COOL_LOAD;
        end else if (refill_q == REFILL_LAST) begin
          state_d = ST_FAULT;
        end else begin
          refill_d = refill_q + FW'(1);
        end
      end
      ST_WATER: begin
        // Tank running dry outranks a normal end of run.
        if (empty) begin
          state_d  = ST_REFILL;
          refill_d = '0;
        end else if (run_q == '0) begin
          state_d = ST_COOLDOWN;
          cool_d  = COOL_LOAD;
        end else begin
          run_d = run_q - RW'(1);
        end
      end
      ST_COOLDOWN: begin
        if (cool_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q - CW'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    pump_d  = (state_d == ST_REFILL);
    spr_d   = (state_d == ST_WATER) ? ({{(N_ZONES-1){1'b0}}, 1'b1} << zone_d) : '0;
    busy_d  = (state_d != ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      cool_q   <= '0;
      refill_q <= '0;
      last_q   <= LAST_INIT;
      zone_q   <= '0;
      pump_q   <= 1'b0;
      spr_q    <= '0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cool_q   <= cool_d;
      refill_q <= refill_d;
      last_q   <= last_d;
      zone_q   <= zone_d;
      pump_q   <= pump_d;
      spr_q    <= spr_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign io.Pump        = pump_q;
  assign io.Sprinkler   = spr_q;
  assign io.Active_zone = zone_q;
  assign io.Busy        = busy_q;
  assign io.Fault       = fault_q;

endmodule

// File: tb/tb_water_scheduler.sv
// Randomized bench for water_scheduler against a cycle-level behavioural model.
module tb_water_scheduler;

  localparam int N       = 4;
  localparam int DRY     = 64;
  localparam int RUN     = 16;
  localparam int COOL    = 8;
  localparam int TIMEOUT = 64;
  localparam int CYCLES  = 4000;

  localparam int PH_IDLE  = 0;
  localparam int PH_PUMP  = 1;
  localparam int PH_SPRAY = 2;
  localparam int PH_REST  = 3;
  localparam int PH_DEAD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  water_scheduler_if #(.N_ZONES(N)) wif ();

  water_scheduler #(
    .N_ZONES         (N),
    .DRY_THRESH      (8'd64),
    .RUN_CYCLES      (RUN),
    .COOLDOWN_CYCLES (COOL),
    .REFILL_TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .io    (wif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: which activity is underway and how many cycles of it remain.
  int m_phase  = PH_IDLE;
  int m_left   = 0;
  int m_pumped = 0;
  int m_last   = N - 1;
  int m_zone   = 0;

  task automatic model_step(input logic r, input logic [1:0] lvl, input logic [31:0] moist);
    bit got;
    int z;
    if (r) begin
      m_phase = PH_IDLE; m_last = N - 1; m_zone = 0; m_left = 0; m_pumped = 0;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        if (lvl == 2'b00) begin
          m_phase = PH_PUMP; m_pumped = 0;
        end else begin
          got = 0;
          for (int k = 1; k <= N; k++) begin
            z = (m_last + k) % N;
            if (!got && int'(moist[8*z +: 8]) < DRY) begin
              got = 1; m_zone = z; m_last = z; m_left = RUN; m_phase = PH_SPRAY;
            end
          end
        end
      end
      PH_PUMP: begin
        m_pumped++;
        if (lvl == 2'b11) begin
          m_phase = PH_REST; m_left = COOL;
        end else if (m_pumped >= TIMEOUT) begin
          m_phase = PH_DEAD;
        end
      end
      PH_SPRAY: begin
        m_left--;
        if (lvl == 2'b00) begin
          m_phase = PH_PUMP; m_pumped = 0;
        end else if (m_left == 0) begin
          m_phase = PH_REST; m_left = COOL;
        end
      end
      PH_REST: begin
        m_left--;
        if (m_left == 0) m_phase = PH_IDLE;
      end
      default: m_phase = PH_DEAD;
    endcase
  endtask

  function automatic logic [7:0] pick_moist(input bit dry);
    int r;
    r = int'($urandom_range(0, 3));
    if (dry) return (r == 0) ? 8'd63 : 8'($urandom_range(0, 63));
    else     return (r == 0) ? 8'd64 : 8'($urandom_range(64, 255));
  endfunction

  initial begin
    logic [1:0]  lvl;
    logic [31:0] moist;
    int          mode;
    int          seg;

    lvl   = 2'b10;
    moist = '1;
    wif.Water_sensor    = lvl;
    wif.Moisture_sensor = moist;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      seg  = cyc % 500;
      mode = (cyc / 500) % 4;
      rst  = (seg < 2) || ($urandom_range(0, 399) == 0);

      if (mode == 3) begin
        lvl = 2'b11;
        for (int z = 0; z < N; z++) moist[8*z +: 8] = 8'd20;
      end else begin
        if (seg % 40 == 0) begin
          for (int z = 0; z < N; z++) moist[8*z +: 8] = pick_moist($urandom_range(0, 1) == 1);
        end
        if (mode == 2) begin
          lvl = (seg < 3) ? 2'b00 : 2'b01;
        end else if (mode == 0) begin
          lvl = ($urandom_range(0, 59) == 0) ? 2'b00 : 2'b11;
        end else if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) lvl = (lvl == 2'b11) ? lvl : lvl + 2'b01;
          else                           lvl = (lvl == 2'b00) ? lvl : lvl - 2'b01;
        end
      end
      wif.Water_sensor    = lvl;
      wif.Moisture_sensor = moist;

      @(posedge clk);
      model_step(rst, lvl, moist);

      @(negedge clk);
      check("pump",   32'(wif.Pump),        32'(m_phase == PH_PUMP));
      check("spr",    32'(wif.Sprinkler),   (m_phase == PH_SPRAY) ? (32'd1 << m_zone) : 32'd0);
      check("zone",   32'(wif.Active_zone), 32'(m_zone));
      check("busy",   32'(wif.Busy),        32'(m_phase != PH_IDLE));
      check("fault",  32'(wif.Fault),       32'(m_phase == PH_DEAD));
      check("excl",   32'(wif.Pump & (|wif.Sprinkler)), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/water_scheduler.md
# water_scheduler

Sequencer for the home irrigation resource: one tank-refill pump and one shared water supply feeding N sprinkler zones. Scans per-zone moisture sensors, grants the supply round-robin to one dry zone at a time, and refills the tank with hysteresis. Guarantees pump and sprinklers are never on together. Sits above the per-zone water actuators in the smart-home top level and drives their Pump/Sprinkler enables.

## Interface
- N_ZONES, 4: number of sprinkler zones (2..8)
- DRY_THRESH, 8'd64: zone is dry when moisture < DRY_THRESH (unsigned)
- RUN_CYCLES, 16: sprinkler on-time per grant, in clocks (>=1)
- COOLDOWN_CYCLES, 8: all-off gap after each watering or refill (>=1)
- REFILL_TIMEOUT, 64: maximum pump on-time before fault (>=1)
- CLK  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Moisture_sensor  in  8*N_ZONES  zone z at bits [8z+7:8z]
- Water_sensor  in  2  tank level: 00 empty, 01 low, 10 mid, 11 full
- Pump  out  1  tank refill pump enable
- Sprinkler  out  N_ZONES  one-hot zone valve enable (or all zero)
- Active_zone  out  clog2(N_ZONES)  zone currently watered; holds last value otherwise
- Busy  out  1  state is not IDLE
- Fault  out  1  sticky refill-timeout flag

## Operation
- States: IDLE, REFILL, WATER, COOLDOWN, FAULT.
- IDLE, level 00: go to REFILL. This has priority over watering.
- IDLE, level != 00, at least one dry zone: go to WATER.
  - Grant the first dry zone scanning upward from (last_grant+1) mod N_ZONES.
  - Load the run counter with RUN_CYCLES-1.
  - Update last_grant.
- IDLE, otherwise: stay.
- REFILL:
  - Pump=1 and the refill counter increments.
  - Level 11: go to COOLDOWN.
  - Refill counter reaches REFILL_TIMEOUT-1 with level still != 11: go to FAULT.
- WATER:
  - Sprinkler[grant]=1 and the run counter decrements.
  - Counter reaches 0: go to COOLDOWN.
  - Level falls to 00 during WATER: abort immediately to REFILL. Abort takes priority over counter expiry in the same cycle.
- COOLDOWN: all outputs off for COOLDOWN_CYCLES cycles, then IDLE.
- FAULT:
  - Pump=0, Sprinkler=0, Fault=1, Busy=1.
  - Exits only on Reset.
- Hysteresis: refill starts only at 00 and stops only at 11. Levels 01 and 10 never start the pump.
- Moisture is sampled only in IDLE. Moisture changes during WATER do not shorten the run.
- Invariant: Pump & |Sprinkler == 0 in every cycle. At most one Sprinkler bit is set.

## Timing
- All outputs are registered and are a function of the current state only.
- A decision sampled at edge k is visible on the outputs after edge k.
- WATER: Sprinkler is high for exactly RUN_CYCLES consecutive cycles when not aborted.
- COOLDOWN: exactly COOLDOWN_CYCLES cycles.
- Dry zone present in IDLE at edge k: Sprinkler asserts after edge k (latency 1).
- Level reaches 11 during REFILL: Pump drops after the next edge.
- Reset sampled high at any edge, including mid-WATER, mid-REFILL or in FAULT, sets after that edge:
  - state IDLE; Pump 0; Sprinkler 0; Busy 0; Fault 0; Active_zone 0
  - last_grant N_ZONES-1, so zone 0 is first; all counters 0.
- Reset dominates all other inputs in the same cycle.
- Counter widths are clog2 of the respective parameter + 1. Counters must not wrap.

## Structure
- Shared package water_pkg:
  - state enum
  - level encodings WL_EMPTY/WL_LOW/WL_MID/WL_FULL
  - default DRY_THRESH
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, last-grant pointer
  - outputs: one-hot grant and encoded index; combinational
  - instantiated once, with req[z] = (moisture_z < DRY_THRESH)
- Everything else stays in water_scheduler: FSM, counters, output registers.

## Test plan
All scenarios use the default parameters.
- Reset released; level 10; zone 2 = 32, others = 200 → Sprinkler=4'b0100 for 16 cycles, Active_zone=2, then 8 cycles all-off, then IDLE.
- All zones = 20 (dry); level 11 held → grants in order 0,1,2,3,0; each 16 cycles on, 8-cycle gaps.
- Level 00 and zone 1 dry in IDLE → REFILL first with Pump=1 and Sprinkler=0. Drive 11 after 10 cycles → Pump drops next edge; 8-cycle cooldown; then zone 1 watered.
- Zone 0 watering, level forced to 00 at cycle 5 → Sprinkler drops next edge, Pump=1 the same cycle. Never Pump & Sprinkler.
- REFILL with level stuck at 01 → Pump high 64 cycles, then FAULT: Pump=0, Fault=1. Stays there; Reset clears to IDLE.
- Reset pulsed mid-WATER (cycle 7) → all outputs 0 next edge; next grant starts from zone 0.
